// File: rtl/switch_input_reader.sv
// Synchronises, debounces and edge-detects a bank of board switches/buttons,
// and holds change events behind a valid/ack handshake for a polling consumer.
module switch_input_reader #(
    parameter int unsigned      WIDTH           = 8,
    parameter int unsigned      DEBOUNCE_CYCLES = 16,
    parameter logic [WIDTH-1:0] RESET_LEVEL     = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_state,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             event_valid,
    input  logic             event_ack,
    output logic [WIDTH-1:0] event_data,
    output logic [WIDTH-1:0] event_mask,
    output logic             event_overflow
);

    localparam int unsigned     CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]            sync1_q;
    logic [WIDTH-1:0]            sync2_q;
    logic [WIDTH-1:0]            state_q, state_d;
    logic [WIDTH-1:0]            rise_q, rise_d;
    logic [WIDTH-1:0]            fall_q, fall_d;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

    logic                        eventValid_q, eventValid_d;
    logic [WIDTH-1:0]            eventData_q, eventData_d;
    logic [WIDTH-1:0]            eventMask_q, eventMask_d;
    logic                        eventOverflow_q, eventOverflow_d;
    logic [WIDTH-1:0]            chg;

    // Each bit counts consecutive cycles its synchronised level disagrees
    // with the accepted level; any agreement restarts the count.
    always_comb begin
        state_d = state_q;
        rise_d  = '0;
        fall_d  = '0;
        cnt_d   = cnt_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (sync2_q[i] == state_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                state_d[i] = sync2_q[i];
                cnt_d[i]   = '0;
                rise_d[i]  = sync2_q[i];
                fall_d[i]  = ~sync2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    assign chg = rise_d | fall_d;

    // An ack coinciding with a new change consumes the old event and
    // captures the new one, so the consumer never loses a transition.
    always_comb begin
        eventValid_d    = eventValid_q;
        eventData_d     = eventData_q;
        eventMask_d     = eventMask_q;
        eventOverflow_d = eventOverflow_q;
        if (chg != '0) begin
            eventValid_d = 1'b1;
            eventData_d  = state_d;
            if (!eventValid_q || event_ack) begin
                eventMask_d     = chg;
                eventOverflow_d = 1'b0;
            end else begin
                eventMask_d     = eventMask_q | chg;
                eventOverflow_d = 1'b1;
            end
        end else if (event_ack && eventValid_q) begin
            eventValid_d    = 1'b0;
            eventMask_d     = '0;
            eventOverflow_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q         <= RESET_LEVEL;
            sync2_q         <= RESET_LEVEL;
            state_q         <= RESET_LEVEL;
            rise_q          <= '0;
            fall_q          <= '0;
            cnt_q           <= '0;
            eventValid_q    <= 1'b0;
            eventData_q     <= '0;
            eventMask_q     <= '0;
            eventOverflow_q <= 1'b0;
        end else begin
            sync1_q         <= sw_in;
            sync2_q         <= sync1_q;
            state_q         <= state_d;
            rise_q          <= rise_d;
            fall_q          <= fall_d;
            cnt_q           <= cnt_d;
            eventValid_q    <= eventValid_d;
            eventData_q     <= eventData_d;
            eventMask_q     <= eventMask_d;
            eventOverflow_q <= eventOverflow_d;
        end
    end

    assign sw_state       = state_q;
    assign sw_rise        = rise_q;
    assign sw_fall        = fall_q;
    assign event_valid    = eventValid_q;
    assign event_data     = eventData_q;
    assign event_mask     = eventMask_q;
    assign event_overflow = eventOverflow_q;

endmodule
